// File: rtl/entropy_harvester_pkg.sv
// Shared types for the entropy harvester: FSM states, von Neumann pair codes and a sizing helper.
package entropy_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        EXTRACT = 3'd4
    } state_e;

    // Pair code is {sample[2i+1], sample[2i]}; only the unequal codes carry a bit.
    typedef enum logic [1:0] {
        VN_DROP_00 = 2'b00,
        VN_KEEP_0  = 2'b01,
        VN_KEEP_1  = 2'b10,
        VN_DROP_11 = 2'b11
    } vn_pair_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/entropy_harvester_raw_sync.sv
// Two-flop synchronizer for the asynchronous latch outputs; the only path from raw_bits into the harvester.
module raw_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    // Next values of the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/entropy_harvester.sv
// Drives the latch array arm/release cycle, debiases captured samples and streams packed bytes.
// Optional repetition health test enabled by defining ENTROPY_HARVESTER_HEALTH_EN.
module entropy_harvester
    import entropy_pkg::*;
#(
    parameter int N_BITS        = 16,
    parameter int ARM_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int REP_LIMIT     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              gen_freeze,
    input  logic [N_BITS-1:0] raw_bits,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              health_fail
);

    localparam int N_PAIRS = N_BITS / 2;
    localparam int CNT_W   = $clog2(max3(ARM_CYCLES, SETTLE_CYCLES, N_PAIRS) + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PAIR_LAST   = CNT_W'(N_PAIRS - 1);

    state_e            state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [CNT_W-1:0]  pair_idx_d, pair_idx_q;
    logic [N_BITS-1:0] sample_d, sample_q;
    logic [7:0]        acc_d, acc_q;
    logic [2:0]        bit_cnt_d, bit_cnt_q;
    logic [7:0]        out_data_d, out_data_q;
    logic              out_valid_d, out_valid_q;
    logic              gen_freeze_d, gen_freeze_q;
    logic              busy_d, busy_q;
    logic              health_fail_d;

    logic [N_BITS-1:0] sync_bits_s;
    logic [1:0]        pair_s;
    logic              keep_s;
    logic              keep_bit_s;
    logic              byte_done_s;
    logic              xfer_ok_s;
    logic              stall_s;
    logic [7:0]        acc_next_s;
    logic              valid_nx_s;

    raw_sync #(.WIDTH(N_BITS)) u_raw_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_bits),
        .q     (sync_bits_s)
    );

    // Select the current pair and decode it into keep / kept-bit.
    always_comb begin
        pair_s = 2'(sample_q >> {pair_idx_q, 1'b0});
        case (vn_pair_e'(pair_s))
            VN_KEEP_0: begin keep_s = 1'b1; keep_bit_s = 1'b0; end
            VN_KEEP_1: begin keep_s = 1'b1; keep_bit_s = 1'b1; end
            VN_DROP_00: begin keep_s = 1'b0; keep_bit_s = 1'b0; end
            default:   begin keep_s = 1'b0; keep_bit_s = 1'b0; end
        endcase
        acc_next_s            = acc_q;
        acc_next_s[bit_cnt_q] = keep_bit_s;
        byte_done_s = (bit_cnt_q == 3'd7);
        xfer_ok_s   = !out_valid_q || out_ready;
        stall_s     = keep_s && byte_done_s && !xfer_ok_s;
    end

    // FSM next state, pair walk, byte packing and output handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pair_idx_d = pair_idx_q;
        sample_d   = sample_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        out_data_d = out_data_q;
        if (out_valid_q && out_ready) begin
            valid_nx_s = 1'b0;
        end else begin
            valid_nx_s = out_valid_q;
        end
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ARM;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == ARM_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = CAPTURE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                sample_d   = sync_bits_s;
                pair_idx_d = CNT_ZERO;
                state_d    = EXTRACT;
            end
            EXTRACT: begin
                if (stall_s) begin
                    state_d = EXTRACT;
                end else begin
                    if (keep_s && byte_done_s) begin
                        out_data_d = acc_next_s;
                        valid_nx_s = 1'b1;
                        acc_d      = 8'h00;
                        bit_cnt_d  = 3'd0;
                    end else if (keep_s) begin
                        acc_d     = acc_next_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        acc_d = acc_q;
                    end
                    // A disabled harvester still finishes the sample it captured.
                    if (pair_idx_q == PAIR_LAST) begin
                        pair_idx_d = CNT_ZERO;
                        cnt_d      = CNT_ZERO;
                        if (enable) begin
                            state_d = ARM;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        pair_idx_d = pair_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        out_valid_d  = valid_nx_s && !health_fail_d;
        gen_freeze_d = (state_d != ARM);
        busy_d       = (state_d != IDLE);
    end

    // Main state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            pair_idx_q   <= CNT_ZERO;
            sample_q     <= {N_BITS{1'b0}};
            acc_q        <= 8'h00;
            bit_cnt_q    <= 3'd0;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            gen_freeze_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pair_idx_q   <= pair_idx_d;
            sample_q     <= sample_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            gen_freeze_q <= gen_freeze_d;
            busy_q       <= busy_d;
        end
    end

`ifdef ENTROPY_HARVESTER_HEALTH_EN
    localparam int                REP_W   = $clog2(REP_LIMIT + 1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

    logic [REP_W-1:0] rep_cnt_d, rep_cnt_q;
    logic             health_fail_q;

    // Count consecutive identical captures; the flag is sticky once the limit is reached.
    always_comb begin
        if (state_q == CAPTURE) begin
            if (sync_bits_s != sample_q) begin
                rep_cnt_d = REP_ONE;
            end else if (rep_cnt_q != REP_MAX) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q;
            end
        end else begin
            rep_cnt_d = rep_cnt_q;
        end
        if (rep_cnt_d == REP_MAX) begin
            health_fail_d = 1'b1;
        end else begin
            health_fail_d = health_fail_q;
        end
    end

    // Health test registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q     <= {REP_W{1'b0}};
            health_fail_q <= 1'b0;
        end else begin
            rep_cnt_q     <= rep_cnt_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign health_fail = health_fail_q;
`else
    // REP_LIMIT only matters with the health test; the flag is a constant 0 here.
    localparam logic REP_CFG = (REP_LIMIT > 32'sd0);
    assign health_fail_d = 1'b0 & REP_CFG;
    assign health_fail   = health_fail_d;
`endif

    assign gen_freeze = gen_freeze_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_entropy_harvester.sv
// Self-checking bench for entropy_harvester: table of harvest runs, directed corner sequences,
// and a randomized run checked against a transaction-level von Neumann model.
module tb_entropy_harvester;

`ifdef ENTROPY_HARVESTER_HEALTH_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        gen_freeze;
    logic [15:0] raw_bits;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        health_fail;

    entropy_harvester dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .gen_freeze  (gen_freeze),
        .raw_bits    (raw_bits),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic prev_gf   = 1'b1;
    logic arm_start = 1'b0;
    logic hs        = 1'b0;

    bit         kept_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [15:0] ra;
        logic [15:0] rb;
        int          nh;
        int          exp_bytes;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
        logic        exp_health;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        raw_bits  = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        prev_gf   = 1'b1;
        arm_start = 1'b0;
        hs        = 1'b0;
    endtask

    // One cycle: sample at the falling edge, then drive out_ready for the coming rising edge.
    task automatic step(input logic rdy);
        @(negedge clk);
        out_ready = rdy;
        arm_start = (gen_freeze == 1'b0) && prev_gf;
        prev_gf   = gen_freeze;
        hs        = out_valid && out_ready;
    endtask

    // Reference: keep the first bit of every unequal pair, pack LSB-first into bytes.
    task automatic model_harvest(input logic [15:0] s);
        for (int i = 0; i < 8; i++) begin
            logic a;
            logic b;
            logic [7:0] v;
            a = s[2*i+1];
            b = s[2*i];
            if (a != b) kept_q.push_back(a);
            if (kept_q.size() == 8) begin
                for (int j = 0; j < 8; j++) v[j] = kept_q[j];
                exp_q.push_back(v);
                kept_q.delete();
            end
        end
    endtask

    task automatic run_harvests(input logic [15:0] ra, input logic [15:0] rb, input int nh,
                                output int nbytes, output int arms,
                                output logic [7:0] first_b, output logic [7:0] last_b);
        nbytes  = 0;
        arms    = 0;
        first_b = 8'h00;
        last_b  = 8'h00;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < nh * 16 + 60; c++) begin
            step(1'b1);
            if (hs) begin
                if (nbytes == 0) first_b = out_data;
                last_b = out_data;
                nbytes++;
            end
            if (arm_start) begin
                if (arms == nh) enable = 1'b0;
                else raw_bits = (arms % 2 == 1) ? rb : ra;
                arms++;
            end
        end
    endtask

    initial begin
        int          nbytes;
        int          arms;
        int          cyc;
        int          lowcnt;
        logic [7:0]  first_b;
        logic [7:0]  last_b;
        logic        seen;
        logic        stable;
        logic        stopped;
        logic        prev_stall;
        logic        rdy;
        logic [7:0]  prev_data;
        logic [7:0]  held;
        logic [15:0] s;

        vecs[0] = '{16'hAAAA, 16'hAAAA, 1, 1, 8'hFF, 8'hFF, 1'b0};
        vecs[1] = '{16'h5555, 16'h5555, 1, 1, 8'h00, 8'h00, 1'b0};
        vecs[2] = '{16'h0009, 16'h0009, 3, 0, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{16'h0009, 16'h0009, 4, HEALTH ? 0 : 1, 8'hAA, 8'hAA, HEALTH};
        vecs[4] = '{16'h000F, 16'h000F, 4, 0, 8'h00, 8'h00, HEALTH};
        vecs[5] = '{16'hAAAA, 16'hAAAA, 6, HEALTH ? 3 : 6, 8'hFF, 8'hFF, HEALTH};
        vecs[6] = '{16'hAAAA, 16'h5555, 6, 6, 8'hFF, 8'h00, 1'b0};
        vecs[7] = '{16'h0006, 16'h0006, 4, HEALTH ? 0 : 1, 8'h55, 8'h55, HEALTH};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 2, 0, 8'h00, 8'h00, 1'b0};
        vecs[9] = '{16'h9999, 16'h9999, 1, 1, 8'hAA, 8'hAA, 1'b0};

        // Reset values.
        do_reset();
        check("rst_gen_freeze", gen_freeze, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_health", health_fail, 0);

        // Table of complete harvest runs.
        for (int v = 0; v < 10; v++) begin
            run_harvests(vecs[v].ra, vecs[v].rb, vecs[v].nh, nbytes, arms, first_b, last_b);
            check($sformatf("vec%0d_harvests", v), arms, vecs[v].nh + 1);
            check($sformatf("vec%0d_bytes", v), nbytes, vecs[v].exp_bytes);
            check($sformatf("vec%0d_health", v), health_fail, vecs[v].exp_health);
            check($sformatf("vec%0d_idle", v), busy, 0);
            if (vecs[v].exp_bytes > 0) begin
                check($sformatf("vec%0d_first", v), first_b, vecs[v].exp_first);
                check($sformatf("vec%0d_last", v), last_b, vecs[v].exp_last);
            end
        end

        // Arm/settle/capture/extract timing and single-cycle valid pulse.
        do_reset();
        raw_bits = 16'hAAAA;
        enable   = 1'b1;
        for (int c = 0; c < 10 && !arm_start; c++) step(1'b1);
        check("t1_arm_seen", arm_start, 1);
        cyc    = 0;
        lowcnt = 1;
        for (int c = 0; c < 40; c++) begin
            step(1'b1);
            cyc++;
            if (out_valid) break;
            if (gen_freeze == 1'b0) lowcnt++;
        end
        check("t1_arm_len", lowcnt, 4);
        check("t1_latency", cyc, 16);
        check("t1_data", out_data, 8'hFF);
        enable = 1'b0;
        step(1'b1);
        check("t1_valid_pulse", out_valid, 0);

        // Backpressure: first byte held, second stalls extraction, both delivered back to back.
        do_reset();
        raw_bits = 16'hAAAA;
        enable   = 1'b1;
        for (int c = 0; c < 40 && !out_valid; c++) step(1'b0);
        check("bp_first_valid", out_valid, 1);
        held   = out_data;
        stable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step(1'b0);
            if (!out_valid || out_data != held) stable = 1'b0;
        end
        check("bp_held_stable", stable, 1);
        check("bp_held_data", held, 8'hFF);
        check("bp_stall_busy", busy, 1);
        check("bp_stall_freeze", gen_freeze, 1);
        enable = 1'b0;
        step(1'b1);
        check("bp_hs1", hs, 1);
        check("bp_byte1", out_data, 8'hFF);
        step(1'b1);
        check("bp_hs2", hs, 1);
        check("bp_byte2", out_data, 8'hFF);
        step(1'b1);
        check("bp_drained", out_valid, 0);
        check("bp_idle", busy, 0);

        // Enable dropped in the second ARM cycle aborts the harvest.
        do_reset();
        raw_bits = 16'hAAAA;
        enable   = 1'b1;
        for (int c = 0; c < 10 && !arm_start; c++) step(1'b1);
        check("drop_arm_seen", arm_start, 1);
        step(1'b1);
        enable = 1'b0;
        step(1'b1);
        check("drop_freeze", gen_freeze, 1);
        check("drop_busy", busy, 0);
        seen = 1'b0;
        repeat (30) begin
            step(1'b1);
            if (out_valid) seen = 1'b1;
        end
        check("drop_no_byte", seen, 0);

        // Asynchronous reset while extracting with a byte pending.
        do_reset();
        raw_bits = 16'hAAAA;
        enable   = 1'b1;
        for (int c = 0; c < 40 && !out_valid; c++) step(1'b0);
        check("arst_pre_valid", out_valid, 1);
        repeat (10) step(1'b0);
        check("arst_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_freeze", gen_freeze, 1);
        check("arst_data", out_data, 0);
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_health", health_fail, 0);

        // Randomized samples and backpressure against the reference model.
        do_reset();
        exp_q.delete();
        kept_q.delete();
        enable     = 1'b1;
        stopped    = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        for (int c = 0; c < 8000; c++) begin
            rdy = stopped ? 1'b1 : ($urandom_range(0, 3) != 32'd0);
            step(rdy);
            if (prev_stall && !health_fail) begin
                check("rnd_hold_valid", out_valid, 1);
                check("rnd_hold_data", out_data, prev_data);
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rnd_unexpected_byte: got 0x%0h with no byte outstanding", out_data);
                end else begin
                    check("rnd_byte", out_data, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (arm_start && !stopped) begin
                if (c >= 3000) begin
                    enable  = 1'b0;
                    stopped = 1'b1;
                end else begin
                    s        = 16'($urandom);
                    raw_bits = s;
                    model_harvest(s);
                end
            end
            if (stopped && !busy && !out_valid) break;
        end
        check("rnd_stopped", stopped, 1);
        check("rnd_idle", busy, 0);
        check("rnd_leftover", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
